// File: rtl/ulpi_reg_arbiter_if.sv
// Requester and ULPI link command/rx signals for the register arbiter.
// slave: the arbiter side. master: requesters plus link, as driven by the surroundings.
interface ulpi_reg_arbiter_if;
  // Requester 0
  logic       req0;
  logic       we0;
  logic [5:0] addr0;
  logic [7:0] wdata0;
  logic       ack0;
  logic       err0;
  // Requester 1
  logic       req1;
  logic       we1;
  logic [5:0] addr1;
  logic [7:0] wdata1;
  logic       ack1;
  logic       err1;
  // Shared read data
  logic [7:0] rdata;
  // ULPI link command / register-read side
  logic [7:0] lnk_cmd;
  logic       lnk_cmd_strobe;
  logic       lnk_cmd_busy;
  logic       lnk_stp;
  logic       lnk_rd_valid;
  logic [7:0] lnk_rd_data;

  modport slave (
    input  req0, we0, addr0, wdata0,
    input  req1, we1, addr1, wdata1,
    output ack0, err0, ack1, err1, rdata,
    output lnk_cmd, lnk_cmd_strobe, lnk_stp,
    input  lnk_cmd_busy, lnk_rd_valid, lnk_rd_data
  );

  modport master (
    output req0, we0, addr0, wdata0,
    output req1, we1, addr1, wdata1,
    input  ack0, err0, ack1, err1, rdata,
    input  lnk_cmd, lnk_cmd_strobe, lnk_stp,
    output lnk_cmd_busy, lnk_rd_valid, lnk_rd_data
  );
endinterface

// File: rtl/ulpi_reg_arbiter.sv
// Two-port round-robin arbiter turning register requests into ULPI TX CMD sequences,
// with a per-access link-wait timeout. All outputs are registered from the next state.
module ulpi_reg_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 64,
  parameter int unsigned TO_W           = $clog2(TIMEOUT_CYCLES) + 1
) (
  input logic               clk,
  input logic               reset_n,
  ulpi_reg_arbiter_if.slave bus
);

  typedef enum logic [2:0] {StIdle, StCmd, StData, StStp, StRdWait, StDone} state_e;

  // Extended-register escape address; not supported, rejected without link activity.
  localparam logic [5:0]      ExtRegAddr = 6'h2F;
  localparam logic [TO_W-1:0] ToLimit    = TO_W'(TIMEOUT_CYCLES - 1);

  state_e          r_state, w_state_d;
  logic            r_grant, w_grant_d;
  logic            r_last,  w_last_d;
  logic            r_we,    w_we_d;
  logic [5:0]      r_addr,  w_addr_d;
  logic [7:0]      r_wdata, w_wdata_d;
  logic [TO_W-1:0] r_cnt,   w_cnt_d;
  logic            r_err,   w_err_d;
  logic [7:0]      r_rd,    w_rd_d;

  logic [7:0] r_cmd,    w_cmd_d;
  logic       r_strobe, w_strobe_d;
  logic       r_stp,    w_stp_d;
  logic       r_ack0,   w_ack0_d;
  logic       r_ack1,   w_ack1_d;
  logic       r_err0,   w_err0_d;
  logic       r_err1,   w_err1_d;
  logic [7:0] r_rdata,  w_rdata_d;

  logic w_accept;
  logic w_limit;

  assign w_accept = r_strobe & ~bus.lnk_cmd_busy;
  assign w_limit  = (r_cnt == ToLimit);

  // State, access context and output registers; reset aborts any access in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= StIdle;
      r_grant  <= 1'b0;
      r_last   <= 1'b1;
      r_we     <= 1'b0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_cnt    <= '0;
      r_err    <= 1'b0;
      r_rd     <= '0;
      r_cmd    <= '0;
      r_strobe <= 1'b0;
      r_stp    <= 1'b0;
      r_ack0   <= 1'b0;
      r_ack1   <= 1'b0;
      r_err0   <= 1'b0;
      r_err1   <= 1'b0;
      r_rdata  <= '0;
    end else begin
      r_state  <= w_state_d;
      r_grant  <= w_grant_d;
      r_last   <= w_last_d;
      r_we     <= w_we_d;
      r_addr   <= w_addr_d;
      r_wdata  <= w_wdata_d;
      r_cnt    <= w_cnt_d;
      r_err    <= w_err_d;
      r_rd     <= w_rd_d;
      r_cmd    <= w_cmd_d;
      r_strobe <= w_strobe_d;
      r_stp    <= w_stp_d;
      r_ack0   <= w_ack0_d;
      r_ack1   <= w_ack1_d;
      r_err0   <= w_err0_d;
      r_err1   <= w_err1_d;
      r_rdata  <= w_rdata_d;
    end
  end

  // Next state: arbitration, byte handshake progress and timeout abort.
  always_comb begin
    w_state_d = r_state;
    w_grant_d = r_grant;
    w_last_d  = r_last;
    w_we_d    = r_we;
    w_addr_d  = r_addr;
    w_wdata_d = r_wdata;
    w_err_d   = r_err;
    w_rd_d    = r_rd;
    w_cnt_d   = r_cnt;
    if (r_state == StCmd || r_state == StData || r_state == StRdWait) begin
      w_cnt_d = r_cnt + TO_W'(1);
    end

    case (r_state)
      StIdle: begin
        if (bus.req0 || bus.req1) begin
          // On contention the port that did not win last time is served.
          w_grant_d = (bus.req0 && bus.req1) ? ~r_last : bus.req1;
          w_last_d  = w_grant_d;
          w_we_d    = w_grant_d ? bus.we1    : bus.we0;
          w_addr_d  = w_grant_d ? bus.addr1  : bus.addr0;
          w_wdata_d = w_grant_d ? bus.wdata1 : bus.wdata0;
          w_rd_d    = '0;
          if (w_addr_d == ExtRegAddr) begin
            w_err_d   = 1'b1;
            w_state_d = StDone;
          end else begin
            w_err_d   = 1'b0;
            w_state_d = StCmd;
          end
        end
      end
      StCmd: begin
        if (w_accept) begin
          w_state_d = r_we ? StData : StRdWait;
        end else if (w_limit) begin
          w_err_d   = 1'b1;
          w_state_d = StDone;
        end
      end
      StData: begin
        if (w_accept) begin
          w_state_d = StStp;
        end else if (w_limit) begin
          w_err_d   = 1'b1;
          w_state_d = StDone;
        end
      end
      StStp: w_state_d = StDone;
      StRdWait: begin
        if (bus.lnk_rd_valid) begin
          w_rd_d    = bus.lnk_rd_data;
          w_state_d = StDone;
        end else if (w_limit) begin
          w_err_d   = 1'b1;
          w_state_d = StDone;
        end
      end
      StDone:  w_state_d = StIdle;
      default: w_state_d = StIdle;
    endcase

    // Every state change restarts the wait counter, so it starts at zero in each wait state.
    if (w_state_d != r_state) begin
      w_cnt_d = '0;
    end
  end

  // Outputs for the state being entered; stable across busy stalls since inputs are latched.
  always_comb begin
    w_cmd_d    = 8'h00;
    w_strobe_d = 1'b0;
    w_stp_d    = 1'b0;
    w_ack0_d   = 1'b0;
    w_ack1_d   = 1'b0;
    w_err0_d   = 1'b0;
    w_err1_d   = 1'b0;
    w_rdata_d  = 8'h00;
    case (w_state_d)
      StCmd: begin
        w_strobe_d = 1'b1;
        w_cmd_d    = {(w_we_d ? 2'b10 : 2'b11), w_addr_d};
      end
      StData: begin
        w_strobe_d = 1'b1;
        w_cmd_d    = w_wdata_d;
      end
      StStp: w_stp_d = 1'b1;
      StDone: begin
        w_ack0_d  = ~w_grant_d;
        w_ack1_d  = w_grant_d;
        w_err0_d  = ~w_grant_d & w_err_d;
        w_err1_d  = w_grant_d & w_err_d;
        w_rdata_d = w_err_d ? 8'h00 : w_rd_d;
      end
      default: ;
    endcase
  end

  assign bus.lnk_cmd        = r_cmd;
  assign bus.lnk_cmd_strobe = r_strobe;
  assign bus.lnk_stp        = r_stp;
  assign bus.ack0           = r_ack0;
  assign bus.ack1           = r_ack1;
  assign bus.err0           = r_err0;
  assign bus.err1           = r_err1;
  assign bus.rdata          = r_rdata;

endmodule

// File: tb/tb_ulpi_reg_arbiter.sv
// Directed bench for ulpi_reg_arbiter: vector table of single accesses plus hand-written
// sequences for arbitration, busy stall, reset abort and read timeout.
module tb_ulpi_reg_arbiter;

  localparam int unsigned TimeoutCycles = 64;

  logic clk     = 1'b0;
  logic reset_n = 1'b0;

  always #5 clk = ~clk;

  ulpi_reg_arbiter_if bus ();

  ulpi_reg_arbiter #(
    .TIMEOUT_CYCLES(TimeoutCycles)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus.slave)
  );

  typedef struct {
    bit         port;
    bit         we;
    logic [5:0] addr;
    logic [7:0] wdata;
    int         rd_delay;    // cycle offset of lnk_rd_valid after the CMD cycle; 0 = none
    logic [7:0] rd_byte;
    int         exp_nbytes;
    logic [7:0] exp_b0;
    logic [7:0] exp_b1;
    int         exp_stp;
    int         exp_lat;     // cycles from the request-sampling edge to the ack cycle
    bit         exp_err;
    logic [7:0] exp_rdata;
  } vec_t;

  vec_t vecs [7];

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic set_req(input bit port, input logic req, input logic we,
                         input logic [5:0] addr, input logic [7:0] wdata);
    if (port) begin
      bus.req1 = req; bus.we1 = we; bus.addr1 = addr; bus.wdata1 = wdata;
    end else begin
      bus.req0 = req; bus.we0 = we; bus.addr0 = addr; bus.wdata0 = wdata;
    end
  endtask

  task automatic idle_inputs();
    set_req(1'b0, 1'b0, 1'b0, 6'h00, 8'h00);
    set_req(1'b1, 1'b0, 1'b0, 6'h00, 8'h00);
    bus.lnk_cmd_busy = 1'b0;
    bus.lnk_rd_valid = 1'b0;
    bus.lnk_rd_data  = 8'h00;
  endtask

  function automatic logic [22:0] outs_all();
    return {bus.lnk_cmd, bus.rdata, bus.lnk_cmd_strobe, bus.lnk_stp,
            bus.ack0, bus.ack1, bus.err0, bus.err1, 1'b0};
  endfunction

  task automatic do_reset();
    idle_inputs();
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
  endtask

  // One access on one port with busy=0; the link answers reads rd_delay cycles after CMD.
  task automatic run_access(input vec_t v, input int idx);
    int cyc = 0, nbytes = 0, stp = 0, lat = -1;
    logic [7:0] b0 = 8'h00, b1 = 8'h00, rd_seen = 8'h00;
    logic err_seen = 1'b0, other_ack = 1'b0;
    set_req(v.port, 1'b1, v.we, v.addr, v.wdata);
    while (lat < 0 && cyc < 100) begin
      @(posedge clk); #1; cyc++;
      bus.lnk_rd_valid = 1'b0;
      if (!v.we && v.rd_delay > 0 && cyc == 1 + v.rd_delay) begin
        bus.lnk_rd_valid = 1'b1;
        bus.lnk_rd_data  = v.rd_byte;
      end
      if (bus.lnk_cmd_strobe) begin
        if (nbytes == 0) b0 = bus.lnk_cmd;
        if (nbytes == 1) b1 = bus.lnk_cmd;
        nbytes++;
      end
      if (bus.lnk_stp) stp++;
      if (v.port ? bus.ack1 : bus.ack0) begin
        lat       = cyc;
        err_seen  = v.port ? bus.err1 : bus.err0;
        rd_seen   = bus.rdata;
        other_ack = v.port ? bus.ack0 : bus.ack1;
        set_req(v.port, 1'b0, v.we, v.addr, v.wdata);
      end
    end
    bus.lnk_rd_valid = 1'b0;
    @(posedge clk); #1;
    check($sformatf("v%0d.nbytes", idx), nbytes, v.exp_nbytes);
    check($sformatf("v%0d.byte0", idx), {24'h0, b0}, {24'h0, v.exp_b0});
    check($sformatf("v%0d.byte1", idx), {24'h0, b1}, {24'h0, v.exp_b1});
    check($sformatf("v%0d.stp", idx), stp, v.exp_stp);
    check($sformatf("v%0d.lat", idx), lat, v.exp_lat);
    check($sformatf("v%0d.err", idx), {31'h0, err_seen}, {31'h0, v.exp_err});
    check($sformatf("v%0d.rdata", idx), {24'h0, rd_seen}, {24'h0, v.exp_rdata});
    check($sformatf("v%0d.other_ack", idx), {31'h0, other_ack}, 32'h0);
    check($sformatf("v%0d.ack_pulse", idx), {30'h0, bus.ack0, bus.ack1}, 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    // port we addr wdata dly rdbyte | nbytes b0 b1 stp lat err rdata
    vecs[0] = '{1'b0, 1'b1, 6'h0A, 8'h55, 0, 8'h00, 2, 8'h8A, 8'h55, 1, 4, 1'b0, 8'h00};
    vecs[1] = '{1'b1, 1'b0, 6'h04, 8'h00, 3, 8'h24, 1, 8'hC4, 8'h00, 0, 5, 1'b0, 8'h24};
    vecs[2] = '{1'b1, 1'b1, 6'h3F, 8'hA5, 0, 8'h00, 2, 8'hBF, 8'hA5, 1, 4, 1'b0, 8'h00};
    vecs[3] = '{1'b0, 1'b0, 6'h00, 8'h00, 1, 8'hFF, 1, 8'hC0, 8'h00, 0, 3, 1'b0, 8'hFF};
    vecs[4] = '{1'b0, 1'b1, 6'h2F, 8'h77, 0, 8'h00, 0, 8'h00, 8'h00, 0, 1, 1'b1, 8'h00};
    vecs[5] = '{1'b1, 1'b0, 6'h2F, 8'h00, 0, 8'h00, 0, 8'h00, 8'h00, 0, 1, 1'b1, 8'h00};
    vecs[6] = '{1'b0, 1'b0, 6'h15, 8'h00, 2, 8'h81, 1, 8'hD5, 8'h00, 0, 4, 1'b0, 8'h81};

    idle_inputs();
    repeat (2) @(posedge clk);
    #1 check("reset.outputs", {9'h0, outs_all()}, 32'h0);
    do_reset();

    for (int i = 0; i < 7; i++) run_access(vecs[i], i);

    // Both ports held: grant alternates starting with port 0 after reset.
    begin
      int order [4];
      int nack = 0, n0 = 0, n1 = 0;
      do_reset();
      set_req(1'b0, 1'b1, 1'b1, 6'h01, 8'h11);
      set_req(1'b1, 1'b1, 1'b1, 6'h02, 8'h22);
      for (int c = 0; c < 60 && nack < 4; c++) begin
        @(posedge clk); #1;
        if (bus.ack0) begin n0++; if (nack < 4) order[nack] = 0; nack++; end
        if (bus.ack1) begin n1++; if (nack < 4) order[nack] = 1; nack++; end
        if (nack >= 4) idle_inputs();
      end
      repeat (3) begin
        @(posedge clk); #1;
        if (bus.ack0) n0++;
        if (bus.ack1) n1++;
      end
      check("arb.nack", nack, 4);
      for (int k = 0; k < 4; k++) begin
        if (k < nack) check($sformatf("arb.order%0d", k), order[k], k % 2);
      end
      check("arb.ack0_cycles", n0, 2);
      check("arb.ack1_cycles", n1, 2);
    end

    // Busy for 10 cycles during DATA: byte held, then the write completes.
    begin
      int cyc = 0, lat = -1, bad = 0, stp = 0;
      logic err_seen = 1'b1;
      set_req(1'b0, 1'b1, 1'b1, 6'h0A, 8'h55);
      while (lat < 0 && cyc < 100) begin
        @(posedge clk); #1; cyc++;
        bus.lnk_cmd_busy = (cyc >= 2 && cyc <= 11);
        if (cyc >= 2 && cyc <= 12 && !(bus.lnk_cmd_strobe && bus.lnk_cmd == 8'h55)) bad++;
        if (bus.lnk_stp) stp++;
        if (bus.ack0) begin
          lat = cyc;
          err_seen = bus.err0;
          set_req(1'b0, 1'b0, 1'b0, 6'h00, 8'h00);
        end
      end
      bus.lnk_cmd_busy = 1'b0;
      check("busy.data_held", bad, 0);
      check("busy.lat", lat, 14);
      check("busy.stp", stp, 1);
      check("busy.err", {31'h0, err_seen}, 32'h0);
    end

    // Reset asserted mid-DATA: outputs clear at once and no ack follows.
    begin
      int acks = 0, strobes = 0;
      @(posedge clk); #1;
      set_req(1'b0, 1'b1, 1'b1, 6'h0A, 8'h55);
      repeat (2) begin @(posedge clk); #1; end
      bus.lnk_cmd_busy = 1'b1;
      check("rst.in_data", {23'h0, bus.lnk_cmd_strobe, bus.lnk_cmd}, 32'h155);
      @(posedge clk); #1;
      reset_n = 1'b0;
      #1 check("rst.outputs", {9'h0, outs_all()}, 32'h0);
      idle_inputs();
      repeat (2) @(posedge clk);
      #1 reset_n = 1'b1;
      repeat (8) begin
        @(posedge clk); #1;
        if (bus.ack0 || bus.ack1) acks++;
        if (bus.lnk_cmd_strobe || bus.lnk_stp) strobes++;
      end
      check("rst.no_ack", acks, 0);
      check("rst.no_link", strobes, 0);
    end

    // Read with no link answer: 64 cycles in RD_WAIT, then err; late data ignored.
    begin
      int cyc = 0, lat = -1, nstrobe = 0, extra = 0;
      logic err_seen = 1'b0;
      logic [7:0] rd_seen = 8'hFF, rd_late = 8'h00;
      set_req(1'b1, 1'b1, 1'b0, 6'h04, 8'h00);
      while (lat < 0 && cyc < 200) begin
        @(posedge clk); #1; cyc++;
        if (bus.lnk_cmd_strobe) nstrobe++;
        if (bus.ack1) begin
          lat = cyc;
          err_seen = bus.err1;
          rd_seen = bus.rdata;
          set_req(1'b1, 1'b0, 1'b0, 6'h00, 8'h00);
          bus.lnk_rd_valid = 1'b1;
          bus.lnk_rd_data  = 8'hEE;
        end
      end
      repeat (5) begin
        @(posedge clk); #1;
        bus.lnk_rd_valid = 1'b0;
        if (bus.ack0 || bus.ack1) extra++;
        rd_late = rd_late | bus.rdata;
      end
      check("to.lat", lat, 66);
      check("to.err", {31'h0, err_seen}, 32'h1);
      check("to.rdata", {24'h0, rd_seen}, 32'h0);
      check("to.strobes", nstrobe, 1);
      check("to.late_ack", extra, 0);
      check("to.late_rdata", {24'h0, rd_late}, 32'h0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
